uart_receive_controller: RTL
============================

Name: uart_receive_controller

Overview:
- UART receiver: the receive end of the serial link whose transmit side is triggered by the debounced button pulse.
- Oversamples the asynchronous rx line at 16x baud, frames 8N1 (optionally 8E1) characters and presents each byte on a valid/ready holding register for the CPU's I/O logic.
- Flags framing errors and overruns as one-cycle pulses.

Parameters:
- CLK_FREQ, 100000000, input clock frequency in Hz.
- BAUD, 9600, line rate in bit/s. DIV = CLK_FREQ/(BAUD*16), integer-truncated; elaboration error if DIV < 1.
- DATA_BITS, 8, data bits per frame, LSB first; legal range 5..8.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-high reset.
- rx  input  1  serial line; idles high; asynchronous to clk.
- rx_ready  input  1  consumer accepts rx_data this cycle.
- rx_data  output  DATA_BITS  received byte; stable while rx_valid=1.
- rx_valid  output  1  rx_data holds an unconsumed byte.
- frame_err  output  1  one-cycle pulse: stop bit sampled 0, or parity mismatch (feature enabled).
- overrun  output  1  one-cycle pulse: a good frame arrived while the holding register was still full.

Behaviour:
- Reset values: rx_data=0, rx_valid=0, frame_err=0, overrun=0, FSM=IDLE, tick counter=0, sample counter=0.
- rx passes through 2 flip-flops, both reset to 1; the FSM sees only the synchronised value rxs.
- Tick generator: counter 0..DIV-1, emits tick for one clk at DIV-1, then wraps to 0. Free-running and never reset by the FSM.
- sample counter: 4 bits, advances on tick only.
- IDLE: rxs=0 -> START with sample counter=0.
- START: at sample counter 7 (mid start bit):
  - rxs=1 -> false start, return to IDLE, no flags.
  - rxs=0 -> DATA, with bit index=0 and sample counter=0.
- DATA: at sample counter 15, shift rxs into the shift register MSB side (LSB-first line order) and increment bit index. After DATA_BITS bits -> PARITY if the feature is enabled, else STOP.
- STOP: at sample counter 15:
  - rxs=1 -> good frame, go to IDLE.
  - rxs=0 -> frame_err pulse, byte discarded, go to WAIT_IDLE.
- WAIT_IDLE (break/glitch recovery): stay until rxs=1, then IDLE. No new frame is accepted meanwhile.
- Good frame load, in the cycle after the stop sample:
  - rx_valid=0, or rx_ready=1 that same cycle -> rx_data<=byte, rx_valid<=1.
  - Otherwise -> overrun pulse; old rx_data and rx_valid are kept; new byte dropped.
- Handshake: rx_valid=1 and rx_ready=1 with no simultaneous load -> rx_valid<=0 next cycle. rx_ready while rx_valid=0 is ignored.
- frame_err and overrun are never high in the same cycle.
- Latency: rx_valid rises (8+16*(DATA_BITS+1))*DIV + 3 ±DIV clk after the rx falling edge, i.e. 155 clk at DIV=1, 8 bits, no parity.
- rst mid-frame: everything returns to reset values immediately, and the partial byte is lost. After rst deassert, a line held low is treated as a start bit.

Optional Feature:
- Macro UART_RX_PARITY_EN.
- Defined:
  - PARITY state between DATA and STOP; sampled at sample counter 15.
  - Even parity: XOR of data bits and parity bit must be 0.
  - Mismatch -> frame_err pulse at the stop sample, byte discarded, FSM still goes through STOP (then IDLE or WAIT_IDLE).
  - Latency grows by 16*DIV.
- Undefined: no PARITY state, no parity logic; 8N1 only.

Test Plan:
- Bench params CLK_FREQ=1600000, BAUD=100000 (DIV=1, 16 clk/bit), rx_ready=1.
- Send 0xA5 8N1 -> rx_valid pulses once with rx_data=0xA5 at 155 clk after start edge; frame_err=overrun=0.
- rx_ready=0; send 0x3C then 0xC3 -> first byte held (rx_data=0x3C, rx_valid=1); overrun pulses once after second stop bit; rx_data stays 0x3C. Then rx_ready=1 -> rx_valid=0 next cycle.
- rx low glitch of 4 clk in IDLE -> START aborts at mid-sample; no rx_valid, no flags, FSM back in IDLE.
- Send 0x55 with stop bit 0, then hold rx low 40 clk -> frame_err one-cycle pulse, no rx_valid; FSM stays WAIT_IDLE until rx=1. Next 0x0F frame received correctly.
- Assert rst during DATA bit 3 of 0xFF -> all outputs 0 within the rst cycle. After release, next frame 0x81 received as 0x81.
- UART_RX_PARITY_EN defined: send 0x07 with parity bit 1 -> rx_data=0x07, rx_valid. Same byte with parity 0 -> frame_err pulse, no rx_valid.

Source files
------------

// File: rtl/uart_receive_controller.sv
// 16x-oversampling UART receiver with a valid/ready holding register.
// Define UART_RX_PARITY_EN to add an even-parity bit between data and stop (8E1).
module uart_receive_controller #(
    parameter int CLK_FREQ  = 100000000,
    parameter int BAUD      = 9600,
    parameter int DATA_BITS = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    input  logic                 rx_ready,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 frame_err,
    output logic                 overrun
);

    localparam int DIV = CLK_FREQ / (BAUD * 16);
    localparam int TW  = (DIV > 1) ? $clog2(DIV) : 1;

    generate
        if (DIV < 1) begin : g_div_check
            $error("uart_receive_controller: CLK_FREQ too low for BAUD (DIV < 1)");
        end
        if (DATA_BITS < 5 || DATA_BITS > 8) begin : g_bits_check
            $error("uart_receive_controller: DATA_BITS must be 5..8");
        end
    endgenerate

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_RX_PARITY_EN
        PARITY,
`endif
        STOP,
        WAIT_IDLE
    } state_t;

    state_t                 state;
    logic [TW-1:0]          tick_cnt;
    logic                   tick;
    logic                   rx_meta;
    logic                   rxs;
    logic [3:0]             sample_cnt;
    logic [2:0]             bit_idx;
    logic [DATA_BITS-1:0]   shift_reg;
    logic                   good;
`ifdef UART_RX_PARITY_EN
    logic                   parity_err;
`endif

    assign tick = (tick_cnt == TW'(DIV - 1));

    // Free-running baud tick; the FSM never resynchronises it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)       tick_cnt <= '0;
        else if (tick) tick_cnt <= '0;
        else           tick_cnt <= tick_cnt + 1'b1;
    end

    // Reset to the idle level so a reset never fakes a start bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
        end else begin
            rx_meta <= rx;
            rxs     <= rx_meta;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            sample_cnt <= '0;
            bit_idx    <= '0;
            shift_reg  <= '0;
            good       <= 1'b0;
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking throughout; the defaults below are overridden by later assignments in the same cycle.
            frame_err <= 1'b0;
            overrun   <= 1'b0;
            good      <= 1'b0;

            // Holding register: a load takes priority over a plain consume.
            if (good) begin
                if (!rx_valid || rx_ready) begin
                    rx_data  <= shift_reg;
                    rx_valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (!rxs) begin
                        state      <= START;
                        sample_cnt <= '0;
                    end
                end
                START: begin
                    if (tick) begin
                        if (sample_cnt == 4'd7) begin
                            if (rxs) begin
                                state <= IDLE;
                            end else begin
                                state      <= DATA;
                                bit_idx    <= '0;
                                sample_cnt <= '0;
                            end
                        end else begin
                            sample_cnt <= sample_cnt + 1'b1;
                        end
                    end
                end
                DATA: begin
                    if (tick) begin
                        sample_cnt <= sample_cnt + 1'b1;
                        if (sample_cnt == 4'd15) begin
                            shift_reg <= {rxs, shift_reg[DATA_BITS-1:1]};
                            bit_idx   <= bit_idx + 1'b1;
                            if (bit_idx == 3'(DATA_BITS - 1)) begin
`ifdef UART_RX_PARITY_EN
                                state <= PARITY;
`else
                                state <= STOP;
`endif
                            end
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (tick) begin
                        sample_cnt <= sample_cnt + 1'b1;
                        if (sample_cnt == 4'd15) begin
                            parity_err <= ^{shift_reg, rxs};
                            state      <= STOP;
                        end
                    end
                end
`endif
                STOP: begin
                    if (tick) begin
                        sample_cnt <= sample_cnt + 1'b1;
                        if (sample_cnt == 4'd15) begin
                            if (!rxs) begin
                                frame_err <= 1'b1;
                                state     <= WAIT_IDLE;
`ifdef UART_RX_PARITY_EN
                            end else if (parity_err) begin
                                frame_err <= 1'b1;
                                state     <= IDLE;
`endif
                            end else begin
                                good  <= 1'b1;
                                state <= IDLE;
                            end
                        end
                    end
                end
                WAIT_IDLE: begin
                    if (rxs) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
